// File: rtl/kyber_pkg.sv
// Shared Kyber constants and parser state type.
// Used by the rejection-sampling parser and its unpack helper.
package kyber_pkg;

    localparam int KYBER_Q            = 3329;
    localparam int KYBER_N            = 256;
    localparam int SHAKE128_RATE_BITS = 1344;
    localparam int XOF_BLOCK_BITS     = 4 * SHAKE128_RATE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BLK,
        ST_PARSE,
        ST_DONE
    } parse_state_t;

endpackage

// File: rtl/parse_unpack.sv
// Splits one byte triple into two 12-bit candidates.
// Each candidate is flagged accepted when it is below Q.
module parse_unpack
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [23:0] triple,
    output logic [11:0] d1,
    output logic [11:0] d2,
    output logic        d1_ok,
    output logic        d2_ok
);

    localparam logic [11:0] QW = 12'(Q);

    assign d1    = {triple[11:8], triple[7:0]};
    assign d2    = {triple[23:16], triple[15:12]};
    assign d1_ok = d1 < QW;
    assign d2_ok = d2 < QW;

endmodule

// File: rtl/sample_ntt_parser.sv
// Kyber Parse rejection sampler: XOF blocks in, N coefficients out.
// Define REJECT_CNT_EN to add the saturating reject_cnt output.
module sample_ntt_parser
    import kyber_pkg::*;
#(
    parameter int BLOCK_BITS = XOF_BLOCK_BITS,
    parameter int N          = KYBER_N,
    parameter int Q          = KYBER_Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BLOCK_BITS-1:0] block_in,
    input  logic                  block_valid,
    output logic                  block_ready,
    output logic [11:0]           coeff,
    output logic [7:0]            coeff_idx,
    output logic                  coeff_valid,
    input  logic                  coeff_ready,
    output logic                  need_more,
    output logic                  done
`ifdef REJECT_CNT_EN
    ,
    output logic [9:0]            reject_cnt
`endif
);

    localparam int NT = BLOCK_BITS / 24;
    localparam int TW = $clog2(NT);
    localparam int CW = $clog2(N + 1);

    parse_state_t          state;
    logic [BLOCK_BITS-1:0] blk;
    logic [TW-1:0]         tptr;
    logic                  half;
    logic [CW-1:0]         count;

    logic [11:0]   d1, d2, cand;
    logic          d1_ok, d2_ok, cand_ok;
    logic          fire, last_xfer, can_eval, last_cand;
    logic [CW-1:0] count_nxt;

    // The block register shifts one triple per d2, so the
    // current triple always sits in the low 24 bits.
    parse_unpack #(.Q(Q)) u_unpack (
        .triple (blk[23:0]),
        .d1     (d1),
        .d2     (d2),
        .d1_ok  (d1_ok),
        .d2_ok  (d2_ok)
    );

    assign cand      = half ? d2 : d1;
    assign cand_ok   = half ? d2_ok : d1_ok;
    assign fire      = coeff_valid && coeff_ready;
    assign last_xfer = fire && (coeff_idx == 8'(N - 1));
    assign can_eval  = (state == ST_PARSE) && (count < CW'(N))
                     && (!coeff_valid || coeff_ready);
    assign last_cand = half && (tptr == TW'(NT - 1));
    assign count_nxt = count + CW'(cand_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            blk         <= '0;
            tptr        <= '0;
            half        <= 1'b0;
            count       <= '0;
            block_ready <= 1'b0;
            coeff       <= '0;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
            need_more   <= 1'b0;
            done        <= 1'b0;
`ifdef REJECT_CNT_EN
            reject_cnt  <= '0;
`endif
        end else begin
            if (fire) coeff_valid <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_WAIT_BLK;
                        block_ready <= 1'b1;
                        done        <= 1'b0;
                        need_more   <= 1'b0;
                        count       <= '0;
`ifdef REJECT_CNT_EN
                        reject_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT_BLK: begin
                    if (block_valid && block_ready) begin
                        blk         <= block_in;
                        tptr        <= '0;
                        half        <= 1'b0;
                        need_more   <= 1'b0;
                        block_ready <= 1'b0;
                        state       <= ST_PARSE;
                    end
                end
                ST_PARSE: begin
                    if (last_xfer) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (can_eval) begin
                        if (cand_ok) begin
                            coeff       <= cand;
                            coeff_idx   <= 8'(count);
                            coeff_valid <= 1'b1;
                            count       <= count_nxt;
                        end
`ifdef REJECT_CNT_EN
                        else if (reject_cnt != 10'h3FF) begin
                            reject_cnt <= reject_cnt + 10'd1;
                        end
`endif
                        if (half) begin
                            blk  <= blk >> 24;
                            tptr <= tptr + TW'(1);
                        end
                        half <= ~half;
                        if (last_cand && count_nxt < CW'(N)) begin
                            need_more   <= 1'b1;
                            block_ready <= 1'b1;
                            state       <= ST_WAIT_BLK;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_ntt_parser.sv
// Directed bench for sample_ntt_parser with a byte-level Parse model.
// Build with REJECT_CNT_EN defined to also check reject_cnt.
module tb_sample_ntt_parser;
    import kyber_pkg::*;

    localparam int BB = XOF_BLOCK_BITS;
    localparam int NB = BB / 8;
    localparam int NT = BB / 24;
    localparam int N  = KYBER_N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BB-1:0] block_in = '0;
    logic          block_valid = 1'b0;
    logic          block_ready;
    logic [11:0]   coeff;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          coeff_ready = 1'b1;
    logic          need_more;
    logic          done;
`ifdef REJECT_CNT_EN
    logic [9:0]    reject_cnt;
`endif

    always #5 clk = ~clk;

    sample_ntt_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .block_in    (block_in),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .coeff       (coeff),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .need_more   (need_more),
        .done        (done)
`ifdef REJECT_CNT_EN
        ,
        .reject_cnt  (reject_cnt)
`endif
    );

    int       vec = 0;
    int       err = 0;
    logic [7:0] bb [NB];
    int       exp_c [N];
    int       exp_wr, rd, rejects;
    bit       mon_en = 1'b0;
    bit       rand_ready = 1'b0;
    bit       prev_stall, nm_seen;
    int       prev_coeff, prev_idx;

    task automatic chk(input string name, input int act, input int req);
        vec++;
        if (act != req) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Parse rule applied straight to the byte list.
    task automatic model_block();
        int b0, b1, b2, d [2];
        for (int t = 0; t < NT; t++) begin
            b0 = bb[3*t];
            b1 = bb[3*t+1];
            b2 = bb[3*t+2];
            d[0] = b0 + 256 * (b1 % 16);
            d[1] = b1 / 16 + 16 * b2;
            for (int j = 0; j < 2; j++) begin
                if (exp_wr < N) begin
                    if (d[j] < KYBER_Q) begin
                        exp_c[exp_wr] = d[j];
                        exp_wr++;
                    end else begin
                        rejects++;
                    end
                end
            end
        end
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NB; k++) bb[k] = 8'(v);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic begin_poly();
        exp_wr = 0;
        rd = 0;
        rejects = 0;
        prev_stall = 1'b0;
        nm_seen = 1'b0;
        mon_en = 1'b1;
        do_start();
    endtask

    task automatic send_block();
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NB; k++) block_in[8*k +: 8] = bb[k];
        block_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (block_ready) ok = 1'b1;
        end
        chk("block_ready_wait", int'(ok), 1);
        @(posedge clk); #1 block_valid = 1'b0;
    endtask

    task automatic wait_done(input int nm_exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        chk("done", int'(done), 1);
        chk("xfer_count", rd, N);
        chk("need_more_seen", int'(nm_seen), nm_exp);
        chk("done_valid_low", int'(coeff_valid), 0);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk); #1;
                coeff_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            forever begin
                @(negedge clk);
                if (mon_en && rst_n) begin
                    if (need_more) nm_seen = 1'b1;
                    if (prev_stall) begin
                        chk("stall_valid", int'(coeff_valid), 1);
                        chk("stall_coeff", int'(coeff), prev_coeff);
                        chk("stall_idx", int'(coeff_idx), prev_idx);
                    end
                    if (coeff_valid && coeff_ready) begin
                        if (rd < exp_wr) begin
                            chk("coeff", int'(coeff), exp_c[rd]);
                            chk("coeff_idx", int'(coeff_idx), rd);
                        end else begin
                            vec++;
                            err++;
                            $display("FAIL extra_coeff: got idx %0d, expected none",
                                     coeff_idx);
                        end
                        rd++;
                    end
                    prev_stall = coeff_valid && !coeff_ready;
                    prev_coeff = int'(coeff);
                    prev_idx   = int'(coeff_idx);
                end
            end
        join_none

        // reset state
        #1;
        chk("rst_block_ready", int'(block_ready), 0);
        chk("rst_coeff_valid", int'(coeff_valid), 0);
        chk("rst_coeff", int'(coeff), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_need_more", int'(need_more), 0);
`ifdef REJECT_CNT_EN
        chk("rst_reject_cnt", int'(reject_cnt), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_block_ready", int'(block_ready), 0);

        // 01 02 03 then zeros
        fill(0);
        bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h03;
        begin_poly();
        model_block();
        chk("pin_a0", exp_c[0], 513);
        chk("pin_a1", exp_c[1], 48);
        send_block();
        chk("latency_pre", int'(coeff_valid), 0);
        @(posedge clk); #1;
        chk("latency_post", int'(coeff_valid), 1);
        chk("first_coeff", int'(coeff), 513);
        wait_done(0);
        chk("done_block_ready", int'(block_ready), 0);

        // boundary values around Q, random backpressure, ignored start
        rand_ready = 1'b1;
        fill(0);
        bb[0] = 8'hFF; bb[1] = 8'h0C; bb[2] = 8'hD0;
        bb[3] = 8'h01; bb[4] = 8'h0D; bb[5] = 8'h00;
        begin_poly();
        model_block();
        chk("pin_b0", exp_c[0], 3327);
        chk("pin_b1", exp_c[1], 3328);
        chk("pin_b2", exp_c[2], 0);
        chk("pin_b_rej", rejects, 1);
        send_block();
        for (int i = 0; i < 200 && rd < 20; i++) @(negedge clk);
        do_start();
        @(negedge clk);
        chk("start_ign_done", int'(done), 0);
        chk("start_ign_ready", int'(block_ready), 0);
        wait_done(0);
`ifdef REJECT_CNT_EN
        chk("rej_cnt_b", int'(reject_cnt), rejects);
`endif

        // all-FF block exhausts, then a zero block finishes
        rand_ready = 1'b0;
        fill(8'hFF);
        begin_poly();
        model_block();
        chk("pin_c_rej", rejects, 2 * NT);
        send_block();
        for (int i = 0; i < 600 && !need_more; i++) @(negedge clk);
        chk("c_need_more", int'(need_more), 1);
        chk("c_block_ready", int'(block_ready), 1);
        chk("c_xfers", rd, 0);
`ifdef REJECT_CNT_EN
        chk("c_reject_cnt", int'(reject_cnt), 448);
`endif
        fill(0);
        model_block();
        send_block();
        chk("c_need_more_clr", int'(need_more), 0);
        wait_done(1);
`ifdef REJECT_CNT_EN
        chk("c_reject_final", int'(reject_cnt), 448);
`endif

        // pseudo-random XOF bytes under random backpressure
        rand_ready = 1'b1;
        begin_poly();
        do begin
            for (int k = 0; k < NB; k++) bb[k] = 8'($urandom_range(0, 255));
            model_block();
            send_block();
        end while (exp_wr < N);
        wait_done(int'(rejects > 0 && exp_wr == N && rd >= 0 ? nm_seen : 1'b0));
`ifdef REJECT_CNT_EN
        chk("d_reject_cnt", int'(reject_cnt), rejects > 1023 ? 1023 : rejects);
`endif

        // reset mid-polynomial, then restart
        rand_ready = 1'b0;
        fill(0);
        begin_poly();
        model_block();
        send_block();
        for (int i = 0; i < 400 && !(coeff_valid && coeff_idx == 8'd100); i++)
            @(negedge clk);
        chk("e_reach_idx100", int'(coeff_idx), 100);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_valid", int'(coeff_valid), 0);
        chk("e_rst_coeff", int'(coeff), 0);
        chk("e_rst_idx", int'(coeff_idx), 0);
        chk("e_rst_ready", int'(block_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("e_idle_valid", int'(coeff_valid), 0);
        chk("e_idle_ready", int'(block_ready), 0);
        begin_poly();
        model_block();
        send_block();
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/sample_ntt_parser.md
Name: sample_ntt_parser

Overview:
- Consumer end of the SHAKE128 XOF in the Kyber768 matrix-generation path.
- Takes 5376-bit squeezed blocks (672 bytes), runs Kyber Parse rejection sampling (12-bit candidates < q = 3329) and streams 256 accepted coefficients over a valid/ready interface to the NTT-domain matrix buffer.
- If a block runs out before 256 coefficients are accepted, it requests and consumes further blocks.

Parameters:
- BLOCK_BITS, 5376, width of one squeezed XOF block; multiple of 24.
- N, 256, coefficients per polynomial.
- Q, 3329, rejection bound; a candidate is accepted iff it is < Q.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; begins a new polynomial. Ignored unless the FSM is in IDLE or DONE.
- block_in  input  BLOCK_BITS  XOF bytes; byte k occupies block_in[8k+7:8k], byte 0 is the first squeezed byte.
- block_valid  input  1  block_in is valid.
- block_ready  output  1  parser can accept a block.
- coeff  output  12  accepted coefficient.
- coeff_idx  output  8  index of coeff, 0..255.
- coeff_valid  output  1  coeff/coeff_idx are valid.
- coeff_ready  input  1  downstream accepts.
- need_more  output  1  current block exhausted and polynomial incomplete.
- done  output  1  all N coefficients transferred; held until the next start.

Behaviour:
- Reset state: FSM=IDLE; all outputs 0; internal block register, byte pointer and coefficient counter cleared.
- Reset is honoured mid-operation in any state: the partial polynomial is discarded and no further coefficients are emitted.
- FSM states:
  - IDLE: start -> WAIT_BLK (done cleared).
  - WAIT_BLK: block_ready=1. On block_valid&&block_ready, latch block_in, set byte pointer to 0, clear need_more -> PARSE.
  - PARSE: block_ready=0. Each cycle evaluates at most one candidate, in the order d1 then d2 of each byte triple:
    - d1 = b0 + 256*(b1 & 0xF); d2 = (b1 >> 4) + 16*b2, where b0..b2 are bytes 3t, 3t+1, 3t+2.
    - Candidate accepted (< Q): loaded into the coeff output register with coeff_idx = count; coeff_valid=1; count increments.
    - Candidate rejected: skipped; no output.
    - A candidate is evaluated only when the output register is empty or is transferring this cycle (coeff_valid&&coeff_ready). Throughput is 1 coefficient/cycle with coeff_ready held high.
    - Latency: the first candidate is evaluated the cycle after the block handshake; an accepted d1 of triple 0 shows coeff_valid one cycle after that.
  - Exhaustion: after d2 of triple BLOCK_BITS/24-1 (triple 223) with count < N -> need_more=1, FSM -> WAIT_BLK. A pending output still drains during this.
  - Completion: when the N-th coefficient transfers (coeff_valid&&coeff_ready with coeff_idx=N-1) -> DONE; done=1 the next cycle. Remaining candidates in the block are discarded.
  - DONE: done held high. start -> WAIT_BLK with done=0 and count=0.
- Simultaneous events:
  - Final candidate of a block accepted while count reaches N: go to DONE, need_more stays 0.
  - start while in PARSE or WAIT_BLK is ignored.
- Backpressure: coeff and coeff_idx stay stable while coeff_valid=1 and coeff_ready=0. No candidate is lost or skipped.

Optional Feature:
- REJECT_CNT_EN defined: adds output reject_cnt[9:0]. It counts rejected candidates for the current polynomial, clears on start and on reset, and saturates at 1023.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- kyber_pkg holds: KYBER_Q=3329, KYBER_N=256, SHAKE128_RATE_BITS=1344, XOF_BLOCK_BITS=5376 (=4*rate), and the parser state enum typedef.
- One sub-module, parse_unpack (combinational): takes 3 bytes, produces d1/d2 and their two accept flags. Instantiated once.

Test Plan:
- Block starting 01 02 03, rest 0x00, coeff_ready=1 -> coeff 513 (idx 0), 48 (idx 1), then zeros; done after 256 transfers; need_more never 1.
- Triples FF 0C D0 / 01 0D 00 -> 3327 accepted (idx 0), 3328 accepted (idx 1), 3329 rejected, 0 accepted (idx 2).
- All-0xFF block -> 448 candidates all rejected; need_more=1 and FSM in WAIT_BLK; a second all-0x00 block then yields 256 zeros and done; reject_cnt=448 with REJECT_CNT_EN.
- Random coeff_ready (50% duty) on a block from the SHAKE128 XOF (seed f8f1…5598) -> coefficient sequence matches the Python Parse golden model; values stable under stall.
- rst_n pulled low for 1 cycle at coeff_idx 100 -> all outputs 0 asynchronously; a subsequent start plus block restarts from idx 0.
- start asserted during PARSE -> ignored; idx sequence continues uninterrupted.
